// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM stage. Speed words become complementary,
// dead-time protected gates; blanked over-current latches a sticky shutdown.
module mtr_drv_side #(
  parameter int DEAD_TIME    = 32,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] i_cnt,
  input  logic [10:0] i_spd,     // spd[11:1]; the LSB never reaches the duty
  input  logic        i_ovr_i,
  input  logic        i_shtdwn,
  output logic        o_pwm1,
  output logic        o_pwm2,
  output logic        o_qual
);
  logic [10:0] r_duty_q;
  logic        r_pwm_sig;
  logic [6:0]  r_dead_cnt;
  logic [7:0]  r_blank_cnt;
  logic [1:0]  r_ovr_sync;
  logic        r_pwm1, r_pwm2;
  logic        w_pwm_nxt, w_dead_done, w_blank_done, w_pwm1_nxt, w_pwm2_nxt;

  assign w_pwm_nxt    = (i_cnt < r_duty_q);
  assign w_dead_done  = (r_dead_cnt == 7'(DEAD_TIME));
  assign w_blank_done = (r_blank_cnt == 8'(BLANK_CYCLES));
  assign w_pwm1_nxt   = r_pwm_sig & w_dead_done & ~i_shtdwn;
  assign w_pwm2_nxt   = ~r_pwm_sig & w_dead_done & ~i_shtdwn;

  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;
  assign o_qual = r_ovr_sync[1] & (r_pwm1 | r_pwm2) & w_blank_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_q    <= 11'h400;
      r_pwm_sig   <= 1'b0;
      r_dead_cnt  <= '0;
      r_blank_cnt <= '0;
      r_ovr_sync  <= '0;
      r_pwm1      <= 1'b0;
      r_pwm2      <= 1'b0;
    end else begin
      if (i_cnt == 11'h7FF) r_duty_q <= {~i_spd[10], i_spd[9:0]};
      r_pwm_sig <= w_pwm_nxt;
      // Edge seen on the value being loaded (r_pwm_sig acts as the previous
      // sample), so a gate rises DEAD_TIME+1 clocks after the pwm_sig edge.
      if (w_pwm_nxt != r_pwm_sig)  r_dead_cnt <= '0;
      else if (!w_dead_done)       r_dead_cnt <= r_dead_cnt + 7'd1;
      r_pwm1 <= w_pwm1_nxt;
      r_pwm2 <= w_pwm2_nxt;
      if ((w_pwm1_nxt != r_pwm1) || (w_pwm2_nxt != r_pwm2)) r_blank_cnt <= '0;
      else if (!w_blank_done)      r_blank_cnt <= r_blank_cnt + 8'd1;
      r_ovr_sync <= {r_ovr_sync[0], i_ovr_i};
    end
  end
endmodule

module mtr_drv #(
  parameter int DEAD_TIME    = 32,
  parameter int BLANK_CYCLES = 64,
  parameter int OVR_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        OVR_I_shtdwn
);
  localparam int NUM_SIDES = 2;   // [0] left, [1] right

  logic [10:0]                 r_cnt;
  logic                        r_ovr_seen;
  logic [3:0]                  r_ovr_cnt;
  logic                        r_shtdwn;
  logic [NUM_SIDES-1:0][10:0]  w_spd;
  logic [NUM_SIDES-1:0]        w_ovr, w_pwm1, w_pwm2, w_qual;
  logic                        w_end, w_qual_any;

  assign w_spd[0] = lft_spd[11:1];
  assign w_spd[1] = rght_spd[11:1];
  assign w_ovr    = {OVR_I_rght, OVR_I_lft};

  for (genvar g = 0; g < NUM_SIDES; g++) begin : g_side
    mtr_drv_side #(.DEAD_TIME(DEAD_TIME), .BLANK_CYCLES(BLANK_CYCLES)) u_side (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_cnt    (r_cnt),
      .i_spd    (w_spd[g]),
      .i_ovr_i  (w_ovr[g]),
      .i_shtdwn (r_shtdwn),
      .o_pwm1   (w_pwm1[g]),
      .o_pwm2   (w_pwm2[g]),
      .o_qual   (w_qual[g])
    );
  end

  assign w_end      = (r_cnt == 11'h7FF);
  assign w_qual_any = |w_qual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_ovr_seen <= 1'b0;
      r_ovr_cnt  <= '0;
      r_shtdwn   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 11'd1;
      if (w_end) begin
        r_ovr_seen <= 1'b0;
        // An event in the boundary cycle itself still counts for this period.
        if (r_ovr_seen | w_qual_any) begin
          if (r_ovr_cnt != 4'hF) r_ovr_cnt <= r_ovr_cnt + 4'd1;
          if (({1'b0, r_ovr_cnt} + 5'd1) >= 5'(OVR_LIMIT)) r_shtdwn <= 1'b1;
        end else begin
          r_ovr_cnt <= '0;
        end
      end else if (w_qual_any) begin
        r_ovr_seen <= 1'b1;
      end
    end
  end

  assign OVR_I_shtdwn = r_shtdwn;
  assign PWM1_lft     = w_pwm1[0];
  assign PWM2_lft     = w_pwm2[0];
  assign PWM1_rght    = w_pwm1[1];
  assign PWM2_rght    = w_pwm2[1];
endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: random and directed stimulus against a waveform-level model of
// the motor PWM stage (duty arithmetic, dead-time history window, period counts).
module tb_mtr_drv;
  localparam int D = 32;
  localparam int P = 2048;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [11:0] lft_spd = '0, rght_spd = '0;
  logic        OVR_I_lft = 1'b0, OVR_I_rght = 1'b0;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, OVR_I_shtdwn;

  int n_cmp = 0, n_err = 0;

  mtr_drv dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .OVR_I_lft(OVR_I_lft), .OVR_I_rght(OVR_I_rght),
    .PWM1_lft(PWM1_lft), .PWM2_lft(PWM2_lft),
    .PWM1_rght(PWM1_rght), .PWM2_rght(PWM2_rght), .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  always #10 clk = ~clk;

  // model state: n = clock edges since reset release
  int n;
  int duty[2];
  int hist[2][0:D];   // last D+1 pwm samples per side; -1 = reset state
  bit exp_g[4];       // PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght
  bit shd_exp, shd_prev;
  int shd_at;         // edge at which shutdown is expected, -1 = never
  int last_gedge_r;
  int acc[4], hi[4];  // gate high counts over the current / last full period

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int duty_of(input logic [11:0] spd);
    int s;
    s = $signed(spd);
    return ((s >>> 1) + 1024) & 2047;
  endfunction

  function automatic logic [11:0] rnd_spd();
    case ($urandom_range(0, 5))
      0: return 12'h800;
      1: return 12'h7FF;
      2: return 12'h000;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    duty[0] = 1024; duty[1] = 1024;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i <= D; i++) hist[s][i] = -1;
    for (int k = 0; k < 4; k++) exp_g[k] = 1'b0;
    shd_exp = 1'b0; shd_prev = 1'b0; shd_at = -1;
    last_gedge_r = -1000;
  endtask

  // A gate is high when its pwm level has held for the last D+1 samples.
  task automatic model_edge();
    int pos;
    bit a1, a0;
    bit g[4];
    n++;
    pos = (n - 1) % P;
    for (int s = 0; s < 2; s++) begin
      a1 = 1'b1; a0 = 1'b1;
      for (int i = 0; i <= D; i++) begin
        if (hist[s][i] != 1) a1 = 1'b0;
        if (hist[s][i] != 0) a0 = 1'b0;
      end
      g[2*s]   = a1 && !shd_prev;
      g[2*s+1] = a0 && !shd_prev;
      for (int i = 0; i < D; i++) hist[s][i] = hist[s][i+1];
      hist[s][D] = (pos < duty[s]) ? 1 : 0;
    end
    if (pos == P - 1) begin
      duty[0] = duty_of(lft_spd);
      duty[1] = duty_of(rght_spd);
    end
    if (g[2] != exp_g[2] || g[3] != exp_g[3]) last_gedge_r = n;
    exp_g    = g;
    shd_exp  = (shd_at >= 0) && (n >= shd_at);
    shd_prev = shd_exp;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gates", {28'd0, PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght},
                 {28'd0, exp_g[0], exp_g[1], exp_g[2], exp_g[3]});
    chk("shtdwn", {31'd0, OVR_I_shtdwn}, {31'd0, shd_exp});
    if (n % P == 1) acc = '{0, 0, 0, 0};
    acc[0] += int'(PWM1_lft);  acc[1] += int'(PWM2_lft);
    acc[2] += int'(PWM1_rght); acc[3] += int'(PWM2_rght);
    if (n % P == 0) hi = acc;
  endtask

  // Called at a falling edge; reset drops mid-cycle and outputs must clear at once.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_gates", {28'd0, PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}, 32'd0);
    chk("rst_shd", {31'd0, OVR_I_shtdwn}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int per, pos, dt;
    @(negedge clk);
    do_reset();

    // zero speed left, full positive right
    lft_spd = 12'h000; rght_spd = 12'h7FF;
    repeat (3*P) cyc();
    chk("zero_pwm1_lft", hi[0], 992);
    chk("zero_pwm2_lft", hi[1], 992);
    chk("full_pwm1_rght", hi[2], 2015);
    chk("full_pwm2_rght", hi[3], 0);

    // full negative right
    rght_spd = 12'h800;
    repeat (3*P) cyc();
    chk("neg_pwm1_rght", hi[2], 0);
    chk("neg_pwm2_rght", hi[3], 2048);

    // mid-period speed change at cnt==500
    repeat (500) cyc();
    lft_spd = 12'h400;
    repeat (P - 500) cyc();
    chk("mid_cur_period", hi[0], 992);
    repeat (P) cyc();
    chk("mid_next_period", hi[0], 1504);

    // random speeds, changed at arbitrary points in the period
    repeat (4*P) begin
      if ($urandom_range(0, 299) == 0) lft_spd = rnd_spd();
      if ($urandom_range(0, 299) == 0) rght_spd = rnd_spd();
      cyc();
    end

    // reset mid-period while PWM2_lft is high; duty restarts at 0x400
    lft_spd = 12'h800; rght_spd = rnd_spd();
    repeat (P + 700) cyc();
    chk("pre_rst_pwm2_lft", {31'd0, PWM2_lft}, 32'd1);
    do_reset();
    repeat (P) cyc();
    chk("rst_duty_lft", hi[0], 992);
    repeat (P) cyc();

    // sustained over-current on the left
    lft_spd = 12'h000; rght_spd = 12'h000; OVR_I_lft = 1'b1;
    do_reset();
    shd_at = 4*P;
    repeat (4*P + 5) cyc();
    OVR_I_lft = 1'b0;
    repeat (200) cyc();
    chk("shd_sticky", {31'd0, OVR_I_shtdwn}, 32'd1);
    do_reset();

    // over-current in periods 0-2 and 4-6 with a clean period 3
    repeat (7*P + 10) begin
      per = n / P; pos = n % P;
      OVR_I_lft = (per != 3) && (per < 7) && (pos >= 100) && (pos <= 1900);
      cyc();
    end
    OVR_I_lft = 1'b0;
    chk("nonconsec_shd", {31'd0, OVR_I_shtdwn}, 32'd0);

    // right over-current only inside the blanking window after each gate edge
    do_reset();
    rght_spd = 12'h200;
    repeat (6*P) begin
      if ($urandom_range(0, 999) == 0) lft_spd = rnd_spd();
      dt = (n + 1) - last_gedge_r;
      OVR_I_rght = (dt >= 1) && (dt <= 50);
      cyc();
    end
    OVR_I_rght = 1'b0;
    chk("blank_shd", {31'd0, OVR_I_shtdwn}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
